// File: rtl/controlador_barrido.sv
// controlador_barrido: exhaustive test sequencer for a 4-input / 2-output boolean circuit.
// It steps abcd through all 16 input vectors and holds each one for ESPERA+1 cycles so the
// circuit can settle. On the last cycle of each hold it captures {E,F} into tabla, compares the
// pair against ESPERADO and counts the mismatching vectors in errores.
//
// Ports:
//   clk      - clock; all state changes happen on the rising edge
//   rst_b    - asynchronous active-low reset; aborts any sweep and clears every output
//   inicio   - start pulse; accepted only while idle
//   e_in     - E output of the circuit under control
//   f_in     - F output of the circuit under control
//   abcd     - vector driven to the circuit {A,B,C,D}
//   ocupado  - high while a sweep is in progress
//   listo    - high once a sweep has completed; cleared by the next accepted inicio
//   tabla    - captured responses; bits [2i+1:2i] = {E,F} for vector i
//   errores  - number of vectors whose captured pair differs from ESPERADO
//   fallo    - listo and at least one mismatch
module controlador_barrido #(
  parameter int unsigned ESPERA   = 3,
  parameter logic [31:0] ESPERADO = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        inicio,
  input  logic        e_in,
  input  logic        f_in,
  output logic [3:0]  abcd,
  output logic        ocupado,
  output logic        listo,
  output logic [31:0] tabla,
  output logic [4:0]  errores,
  output logic        fallo
);

  // Reload value of the settle counter; ESPERAR lasts exactly ESPERA cycles.
  localparam logic [7:0] ContIni = 8'(ESPERA - 1);

  typedef enum logic [1:0] {StReposo, StEsperar, StMuestrear} estado_e;

  estado_e     state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cont_q, cont_d;
  logic [31:0] tabla_q, tabla_d;
  logic [4:0]  err_q, err_d;
  logic        listo_q, listo_d;
  logic        ocup_q, ocup_d;

  logic [1:0]  pair;
  logic [1:0]  pair_exp;
  logic [4:0]  bit_lo;

  assign pair     = {e_in, f_in};
  assign bit_lo   = {idx_q, 1'b0};
  assign pair_exp = ESPERADO[bit_lo +: 2];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cont_d  = cont_q;
    tabla_d = tabla_q;
    err_d   = err_q;
    listo_d = listo_q;
    ocup_d  = ocup_q;
    unique case (state_q)
      StReposo: begin
        if (inicio) begin
          idx_d   = 4'd0;
          cont_d  = ContIni;
          tabla_d = 32'd0;
          err_d   = 5'd0;
          listo_d = 1'b0;
          ocup_d  = 1'b1;
          state_d = StEsperar;
        end
      end
      StEsperar: begin
        cont_d = cont_q - 8'd1;
        if (cont_q == 8'd0) begin
          state_d = StMuestrear;
        end
      end
      StMuestrear: begin
        tabla_d[bit_lo +: 2] = pair;
        if (pair != pair_exp) begin
          err_d = err_q + 5'd1;
        end
        if (idx_q == 4'd15) begin
          // abcd stays on the last vector after the sweep.
          ocup_d  = 1'b0;
          listo_d = 1'b1;
          state_d = StReposo;
        end else begin
          idx_d   = idx_q + 4'd1;
          cont_d  = ContIni;
          state_d = StEsperar;
        end
      end
      default: state_d = StReposo;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= StReposo;
      idx_q   <= 4'd0;
      cont_q  <= 8'd0;
      tabla_q <= 32'd0;
      err_q   <= 5'd0;
      listo_q <= 1'b0;
      ocup_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cont_q  <= cont_d;
      tabla_q <= tabla_d;
      err_q   <= err_d;
      listo_q <= listo_d;
      ocup_q  <= ocup_d;
    end
  end

  // The vector index doubles as the driven vector.
  assign abcd    = idx_q;
  assign ocupado = ocup_q;
  assign listo   = listo_q;
  assign tabla   = tabla_q;
  assign errores = err_q;
  assign fallo   = listo_q && (err_q != 5'd0);

endmodule

// File: tb/tb_controlador_barrido.sv
// Bench for controlador_barrido: two instances (different expected tables) share one circuit
// model; a timing-based reference model predicts every output and is compared each cycle.
module tb_controlador_barrido;

  localparam int P = 4;  // ESPERA + 1

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        inicio = 1'b0;
  logic        e_in, f_in;
  logic [3:0]  abcd_a, abcd_b;
  logic        ocup_a, ocup_b, listo_a, listo_b, fallo_a, fallo_b;
  logic [31:0] tabla_a, tabla_b;
  logic [4:0]  err_a, err_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  controlador_barrido #(.ESPERA(3), .ESPERADO(32'hEEEE4444)) dut_a (
    .clk(clk), .rst_b(rst_b), .inicio(inicio), .e_in(e_in), .f_in(f_in),
    .abcd(abcd_a), .ocupado(ocup_a), .listo(listo_a), .tabla(tabla_a),
    .errores(err_a), .fallo(fallo_a)
  );

  controlador_barrido #(.ESPERA(3), .ESPERADO(32'h0000_0000)) dut_b (
    .clk(clk), .rst_b(rst_b), .inicio(inicio), .e_in(e_in), .f_in(f_in),
    .abcd(abcd_b), .ocupado(ocup_b), .listo(listo_b), .tabla(tabla_b),
    .errores(err_b), .fallo(fallo_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Circuit model: E=A, F=D, seen through a delay of dly cycles (or random when mode=1).
  int         dly = 0;
  bit         mode = 1'b0;
  logic       rnd_e = 1'b0, rnd_f = 1'b0;
  logic [3:0] hist [8];
  logic [3:0] sel;

  initial for (int j = 0; j < 8; j++) hist[j] = 4'd0;

  always @(posedge clk) begin
    for (int j = 7; j > 0; j--) hist[j] <= hist[j-1];
    hist[0] <= abcd_a;
  end

  always_comb begin
    sel = abcd_a;
    if (dly >= 2) sel = hist[dly-2];
  end

  always @(negedge clk) begin
    rnd_e <= 1'($urandom);
    rnd_f <= 1'($urandom);
  end

  assign e_in = mode ? rnd_e : sel[3];
  assign f_in = mode ? rnd_f : sel[0];

  // Reference model: counts edges since acceptance; vector i is sampled at edge (i+1)*P.
  logic [31:0] esp_a = 32'hEEEE4444;
  logic [31:0] esp_b = 32'h0000_0000;
  bit          m_busy = 1'b0;
  int          m_n = 0;
  logic [3:0]  m_abcd = 4'd0;
  logic [31:0] m_tabla = 32'd0;
  logic [4:0]  m_err_a = 5'd0, m_err_b = 5'd0;
  bit          m_listo = 1'b0;

  always @(posedge clk or negedge rst_b) begin : mdl
    int i;
    if (!rst_b) begin
      m_busy <= 1'b0; m_n <= 0; m_abcd <= 4'd0; m_tabla <= 32'd0;
      m_err_a <= 5'd0; m_err_b <= 5'd0; m_listo <= 1'b0;
    end else if (!m_busy) begin
      if (inicio) begin
        m_busy <= 1'b1; m_n <= 0; m_abcd <= 4'd0; m_tabla <= 32'd0;
        m_err_a <= 5'd0; m_err_b <= 5'd0; m_listo <= 1'b0;
      end
    end else begin
      m_n <= m_n + 1;
      if ((m_n + 1) % P == 0) begin
        i = (m_n + 1) / P - 1;
        m_tabla[2*i +: 2] <= {e_in, f_in};
        if ({e_in, f_in} != esp_a[2*i +: 2]) m_err_a <= m_err_a + 5'd1;
        if ({e_in, f_in} != esp_b[2*i +: 2]) m_err_b <= m_err_b + 5'd1;
        if (i == 15) begin
          m_busy  <= 1'b0;
          m_listo <= 1'b1;
        end else begin
          m_abcd <= 4'(i + 1);
        end
      end
    end
  end

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("abcd_a", 32'(abcd_a), 32'(m_abcd));
    chk("abcd_b", 32'(abcd_b), 32'(m_abcd));
    chk("ocupado_a", 32'(ocup_a), 32'(m_busy));
    chk("ocupado_b", 32'(ocup_b), 32'(m_busy));
    chk("listo_a", 32'(listo_a), 32'(m_listo));
    chk("listo_b", 32'(listo_b), 32'(m_listo));
    chk("tabla_a", tabla_a, m_tabla);
    chk("tabla_b", tabla_b, m_tabla);
    chk("errores_a", 32'(err_a), 32'(m_err_a));
    chk("errores_b", 32'(err_b), 32'(m_err_b));
    chk("fallo_a", 32'(fallo_a), 32'(m_listo && m_err_a != 0));
    chk("fallo_b", 32'(fallo_b), 32'(m_listo && m_err_b != 0));
  end

  // Starts a sweep; pulse = cycle index (after acceptance) at which inicio is driven again.
  task automatic run_sweep(input int pulse);
    int c;
    @(negedge clk);
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    chk("start_listo", 32'(listo_a), 32'd0);
    chk("start_ocupado", 32'(ocup_a), 32'd1);
    chk("start_errores", 32'(err_a), 32'd0);
    c = 0;
    while (c < 200 && !listo_a) begin
      @(negedge clk);
      c++;
      inicio = (c == pulse);
    end
    inicio = 1'b0;
    chk("sweep_len", 32'(c), 32'd64);
    if (pulse == 63) begin
      @(negedge clk);
      chk("late_inicio_ignored", 32'(ocup_a), 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("rst_abcd", 32'(abcd_a), 32'd0);
    chk("rst_tabla", tabla_a, 32'd0);
    chk("rst_ocupado", 32'(ocup_a), 32'd0);
    chk("rst_listo", 32'(listo_a), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_b = 1'b0;
    #1;
    chk("por_abcd", 32'(abcd_a), 32'd0);
    chk("por_errores", 32'(err_a), 32'd0);
    chk("por_fallo", 32'(fallo_a), 32'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_tabla", tabla_a, 32'd0);
    chk("idle_ocupado", 32'(ocup_a), 32'd0);
    chk("idle_listo", 32'(listo_a), 32'd0);

    // Zero-delay circuit against both expected tables.
    dly = 0;
    run_sweep(-1);
    chk("z_tabla", tabla_a, 32'hEEEE4444);
    chk("z_err_a", 32'(err_a), 32'd0);
    chk("z_fallo_a", 32'(fallo_a), 32'd0);
    chk("z_err_b", 32'(err_b), 32'd12);
    chk("z_fallo_b", 32'(fallo_b), 32'd1);

    // Delay within the settle window, then one that lags a full vector.
    dly = 4;
    run_sweep(-1);
    chk("d4_err_a", 32'(err_a), 32'd0);
    do_reset();
    dly = 6;
    run_sweep(-1);
    chk("d6_err_a", 32'(err_a), 32'd15);
    chk("d6_fallo_a", 32'(fallo_a), 32'd1);

    // inicio mid-sweep and on the finishing edge are ignored; restart after listo works.
    dly = 0;
    run_sweep(20);
    run_sweep(63);
    chk("restart_tabla", tabla_a, 32'hEEEE4444);

    // Asynchronous reset part-way through a sweep.
    @(negedge clk);
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    repeat (29) @(negedge clk);
    do_reset();
    run_sweep(-1);
    chk("post_rst_tabla", tabla_a, 32'hEEEE4444);
    chk("post_rst_err_b", 32'(err_b), 32'd12);

    // Random circuit responses and random stray inicio pulses.
    mode = 1'b1;
    for (int s = 0; s < 6; s++) begin
      run_sweep(int'($urandom_range(1, 70)));
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
